// File: rtl/prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch stage: FSM state encodings,
// default decode constants and the two-word test macro.
`ifndef PREFETCH_UNIT_PKG_SV
`define PREFETCH_UNIT_PKG_SV

// True when an opcode word is followed by an immediate/target word.
`define PREFETCH_IS_TWO_WORD(w, imm, br) ((w[9:0] == (imm)) || (w[15:11] == (br)))

package prefetch_unit_pkg;

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    FETCH_IMM = 3'd1,
    HOLD      = 3'd2,
    WAIT_OP   = 3'd3,
    WAIT_IMM  = 3'd4
  } state_t;

  localparam logic [15:0] RESET_ADDR_DEFAULT = 16'h0000;
  localparam logic [9:0]  IMM_SRC_DEFAULT    = 10'h3a0;
  localparam logic [4:0]  BR_CLASS_DEFAULT   = 5'b11100;

endpackage

`endif

// File: rtl/prefetch_unit_instr_len_decode.sv
// Combinational two-word instruction detector; reusable wherever an opcode
// word must be classified as one- or two-word.
module instr_len_decode
  import prefetch_unit_pkg::*;
#(
  parameter logic [9:0] IMM_SRC  = IMM_SRC_DEFAULT,
  parameter logic [4:0] BR_CLASS = BR_CLASS_DEFAULT
) (
  input  logic [15:0] instr,
  output logic        two_word
);

  assign two_word = `PREFETCH_IS_TWO_WORD(instr, IMM_SRC, BR_CLASS);

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch stage: owns the PC, assembles one/two-word instructions
// and hands them to decode. Define PREFETCH_ROM_REG_EN for a registered-output ROM.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter logic [9:0]  IMM_SRC    = IMM_SRC_DEFAULT,
  parameter logic [4:0]  BR_CLASS   = BR_CLASS_DEFAULT
) (
  input  logic        sysclk,
  input  logic        sysreset_n,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_operand,
  output logic        out_has_operand,
  output logic [15:0] out_pc
);

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic        two_word;
  logic        capture_op;
  logic        capture_imm;

  instr_len_decode #(
    .IMM_SRC  (IMM_SRC),
    .BR_CLASS (BR_CLASS)
  ) u_len_decode (
    .instr    (rom_data),
    .two_word (two_word)
  );

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state <= FETCH_OP;
    end else begin
      state <= state_next;
    end
  end

  // Redirect overrides everything, so captures are only raised when it is absent.
  always_comb begin
    state_next  = state;
    capture_op  = 1'b0;
    capture_imm = 1'b0;
    if (redirect_valid) begin
      state_next = FETCH_OP;
    end else begin
      case (state)
`ifdef PREFETCH_ROM_REG_EN
        FETCH_OP:  state_next = WAIT_OP;
        WAIT_OP: begin
          capture_op = 1'b1;
          state_next = two_word ? FETCH_IMM : HOLD;
        end
        FETCH_IMM: state_next = WAIT_IMM;
        WAIT_IMM: begin
          capture_imm = 1'b1;
          state_next  = HOLD;
        end
`else
        FETCH_OP: begin
          capture_op = 1'b1;
          state_next = two_word ? FETCH_IMM : HOLD;
        end
        FETCH_IMM: begin
          capture_imm = 1'b1;
          state_next  = HOLD;
        end
`endif
        HOLD: begin
          if (out_ready) begin
            state_next = FETCH_OP;
          end
        end
        default: state_next = FETCH_OP;
      endcase
    end
  end

  always_comb begin
    rom_addr  = pc;
    out_valid = (state == HOLD);
  end

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_addr;
    end else if (capture_op || capture_imm) begin
      pc_next = pc + 16'd1;
    end
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      pc              <= RESET_ADDR;
      out_instr       <= 16'h0000;
      out_operand     <= 16'h0000;
      out_has_operand <= 1'b0;
      out_pc          <= 16'h0000;
    end else begin
      pc <= pc_next;
      if (capture_op) begin
        out_instr       <= rom_data;
        out_pc          <= pc;
        out_operand     <= 16'h0000;
        out_has_operand <= 1'b0;
      end
      if (capture_imm) begin
        out_operand     <= rom_data;
        out_has_operand <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed scenarios then randomized traffic checked
// against an instruction-level model of the program ROM.
module tb_prefetch_unit;

`ifdef PREFETCH_ROM_REG_EN
  localparam int LAT1 = 2;
  localparam int LAT2 = 4;
`else
  localparam int LAT1 = 1;
  localparam int LAT2 = 2;
`endif

  logic        sysclk = 1'b0;
  logic        sysreset_n = 1'b0;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_operand;
  logic        out_has_operand;
  logic [15:0] out_pc;

  logic [15:0] mem [0:65535];

  int total = 0;
  int bad = 0;

  always #5 sysclk = ~sysclk;

`ifdef PREFETCH_ROM_REG_EN
  always_ff @(posedge sysclk) rom_data <= mem[rom_addr];
`else
  assign rom_data = mem[rom_addr];
`endif

  prefetch_unit dut (
    .sysclk          (sysclk),
    .sysreset_n      (sysreset_n),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_operand     (out_operand),
    .out_has_operand (out_has_operand),
    .out_pc          (out_pc)
  );

  function automatic logic is_two(input logic [15:0] w);
    return (w[9:0] == 10'h3a0) || (w[15:11] == 5'b11100);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    sysreset_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    step();
    step();
    sysreset_n = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic expect_instr(input string tag, input logic [15:0] instr,
                              input logic [15:0] operand, input logic has,
                              input logic [15:0] pc, input int lat);
    int n;
    wait_valid(n);
    chk({tag, "_lat"}, 16'(n), 16'(lat));
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_operand"}, out_operand, operand);
    chk({tag, "_has"}, {15'd0, out_has_operand}, {15'd0, has});
    chk({tag, "_pc"}, out_pc, pc);
    $display("txn %s: pc=%h instr=%h operand=%h has=%0b latency=%0d",
             tag, out_pc, out_instr, out_operand, out_has_operand, n);
  endtask

  initial begin
    logic [15:0] s_instr, s_op, s_pc, mpc, a1, w, exp_op, r_addr;
    logic s_has, prev_stall, rdy, rdr;
    int hs;

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // Reset values and two consecutive one-word instructions
    mem[0] = 16'h2601; mem[1] = 16'hc800; mem[2] = 16'h0000;
    sysreset_n = 1'b0;
    #1;
    step();
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_instr", out_instr, 16'h0000);
    chk("rst_operand", out_operand, 16'h0000);
    chk("rst_has", {15'd0, out_has_operand}, 16'd0);
    chk("rst_pc", out_pc, 16'h0000);
    chk("rst_rom_addr", rom_addr, 16'h0000);
    sysreset_n = 1'b1;
    expect_instr("one_a", 16'h2601, 16'h0000, 1'b0, 16'h0000, LAT1);
    accept();
    chk("one_a_drop", {15'd0, out_valid}, 16'd0);
    expect_instr("one_b", 16'hc800, 16'h0000, 1'b0, 16'h0001, LAT1);
    accept();

    // Immediate-carrying instruction; next fetch from pc 2
    mem[0] = 16'h07a0; mem[1] = 16'hff01; mem[2] = 16'h0000;
    do_reset();
    expect_instr("imm", 16'h07a0, 16'hff01, 1'b1, 16'h0000, LAT2);
    accept();
    expect_instr("imm_next", 16'h0000, 16'h0000, 1'b0, 16'h0002, LAT1);
    accept();

    // Backpressure on a branch-class instruction
    mem[0] = 16'he00f; mem[1] = 16'h0003; mem[2] = 16'h0000;
    do_reset();
    expect_instr("br", 16'he00f, 16'h0003, 1'b1, 16'h0000, LAT2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", {15'd0, out_valid}, 16'd1);
      chk("stall_instr", out_instr, 16'he00f);
      chk("stall_operand", out_operand, 16'h0003);
      chk("stall_pc", out_pc, 16'h0000);
    end
    accept();
    chk("br_single_hs", {15'd0, out_valid}, 16'd0);
    expect_instr("br_next", 16'h0000, 16'h0000, 1'b0, 16'h0002, LAT1);
    accept();

    // Redirect while the immediate word is being fetched
    mem[0] = 16'h07a0; mem[1] = 16'h1111; mem[16'h002a] = 16'h2601;
    do_reset();
    for (int k = 0; k < LAT2 / 2; k++) step();
    chk("redir_imm_novalid", {15'd0, out_valid}, 16'd0);
    redirect_valid = 1'b1; redirect_addr = 16'h002a;
    step();
    redirect_valid = 1'b0;
    expect_instr("redir_imm", 16'h2601, 16'h0000, 1'b0, 16'h002a, LAT1);
    accept();

    // Operand fetch wrapping past 16'hffff
    mem[16'hffff] = 16'h13a0; mem[0] = 16'h30d4; mem[1] = 16'h0000;
    do_reset();
    redirect_valid = 1'b1; redirect_addr = 16'hffff;
    step();
    redirect_valid = 1'b0;
    expect_instr("wrap", 16'h13a0, 16'h30d4, 1'b1, 16'hffff, LAT2);
    accept();
    expect_instr("wrap_next", 16'h0000, 16'h0000, 1'b0, 16'h0001, LAT1);

    // Asynchronous reset while holding an instruction
    mem[0] = 16'h2601;
    chk("pre_rst_valid", {15'd0, out_valid}, 16'd1);
    sysreset_n = 1'b0;
    #1;
    chk("async_rst_valid", {15'd0, out_valid}, 16'd0);
    chk("async_rst_instr", out_instr, 16'h0000);
    chk("async_rst_rom_addr", rom_addr, 16'h0000);
    step();
    sysreset_n = 1'b1;
    expect_instr("post_rst", 16'h2601, 16'h0000, 1'b0, 16'h0000, LAT1);
    accept();

    // Randomized traffic against an instruction-level ROM model
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) w[15:11] = 5'b11100;
        else w[9:0] = 10'h3a0;
      end
      mem[i] = w;
    end
    do_reset();
    mpc = 16'h0000;
    hs = 0;
    prev_stall = 1'b0;
    s_instr = 0; s_op = 0; s_pc = 0; s_has = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_stall) begin
        chk("rnd_stall_valid", {15'd0, out_valid}, 16'd1);
        chk("rnd_stall_instr", out_instr, s_instr);
        chk("rnd_stall_operand", out_operand, s_op);
        chk("rnd_stall_has", {15'd0, out_has_operand}, {15'd0, s_has});
        chk("rnd_stall_pc", out_pc, s_pc);
      end
      rdy = ($urandom_range(0, 2) != 0);
      rdr = ($urandom_range(0, 19) == 0);
      r_addr = ($urandom_range(0, 3) == 0) ? 16'hffff - 16'($urandom_range(0, 3))
                                           : 16'($urandom);
      if (out_valid && rdy) begin
        w = mem[mpc];
        a1 = mpc + 16'd1;
        exp_op = is_two(w) ? mem[a1] : 16'h0000;
        chk("rnd_instr", out_instr, w);
        chk("rnd_operand", out_operand, exp_op);
        chk("rnd_has", {15'd0, out_has_operand}, {15'd0, is_two(w)});
        chk("rnd_pc", out_pc, mpc);
        $display("txn rnd: pc=%h instr=%h operand=%h has=%0b", out_pc, out_instr,
                 out_operand, out_has_operand);
        mpc = is_two(w) ? mpc + 16'd2 : mpc + 16'd1;
        hs++;
      end
      if (rdr) mpc = r_addr;
      prev_stall = out_valid && !rdy && !rdr;
      s_instr = out_instr; s_op = out_operand; s_pc = out_pc; s_has = out_has_operand;
      out_ready = rdy;
      redirect_valid = rdr;
      redirect_addr = r_addr;
      step();
    end
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("rnd_progress", {15'd0, hs > 100}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
